main_mem_arbiter: RTL

// - Shares the single main-memory port (line reads, word writes) between two cache controllers.
//   - Port 0 is the I-side requester; port 1 is the D-side requester.
// - Arbitrates between them round-robin and latches the winner's address and write data.
// - Issues one memory transaction at a time and returns the read line or write completion to the winner.
// - Sits between the cache controllers and the DRAM model/controller. Watchdog aborts hung transactions.

---
 rtl/main_mem_arbiter_pkg.sv | 31 +++
 rtl/main_mem_arbiter_rr_arb2.sv | 46 ++++
 rtl/main_mem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: FSM states, op codes,
// default widths and the read/write op selection helper.
package main_mem_arbiter_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int WORD_W_DEF  = 32;
    localparam int LINE_W_DEF  = 512;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    // A requester raising both read and write is served as a write only.
    function automatic op_e sel_op(input logic wr);
        if (wr) begin
            return OP_WR;
        end else begin
            return OP_RD;
        end
    endfunction

endpackage

// File: rtl/main_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker. Purely combinational; the owner keeps the
// last_grant register and loads last_grant_nxt every cycle.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic       gnt_id,
    output logic       gnt_valid,
    output logic       last_grant_nxt
);

    // Pick the single requester, or the port that did not win last time.
    always_comb begin
        gnt_id         = 1'b0;
        gnt_valid      = 1'b0;
        last_grant_nxt = last_grant;
        if (en) begin
            case (req)
                2'b01: begin
                    gnt_id    = 1'b0;
                    gnt_valid = 1'b1;
                end
                2'b10: begin
                    gnt_id    = 1'b1;
                    gnt_valid = 1'b1;
                end
                2'b11: begin
                    gnt_id    = ~last_grant;
                    gnt_valid = 1'b1;
                end
                default: begin
                    gnt_id    = 1'b0;
                    gnt_valid = 1'b0;
                end
            endcase
            if (gnt_valid) begin
                last_grant_nxt = gnt_id;
            end else begin
                last_grant_nxt = last_grant;
            end
        end else begin
            last_grant_nxt = last_grant;
        end
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// Shares one main-memory port between the I-side (port 0) and D-side
// (port 1) cache controllers: round-robin grant, one transaction in flight,
// latched address/data, watchdog abort, all outputs registered.
module main_mem_arbiter
    import main_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int WORD_W         = WORD_W_DEF,
    parameter int LINE_W         = LINE_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_rd_req,
    input  logic              p0_wr_req,
    input  logic [WORD_W-1:0] p0_wdata,
    output logic [LINE_W-1:0] p0_rdata,
    output logic              p0_ready,
    output logic              p0_err,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_rd_req,
    input  logic              p1_wr_req,
    input  logic [WORD_W-1:0] p1_wdata,
    output logic [LINE_W-1:0] p1_rdata,
    output logic              p1_ready,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_read_req,
    output logic              mem_write_req,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              grant_id
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q,      state_d;
    op_e               op_q,         op_d;
    logic              id_q,         id_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [WORD_W-1:0] wdata_q,      wdata_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              mem_rd_q,     mem_rd_d;
    logic              mem_wr_q,     mem_wr_d;
    logic [LINE_W-1:0] p0_rdata_q,   p0_rdata_d;
    logic [LINE_W-1:0] p1_rdata_q,   p1_rdata_d;
    logic [1:0]        ready_q,      ready_d;
    logic [1:0]        err_q,        err_d;
    logic              busy_q,       busy_d;

    logic [1:0] arb_req_s;
    logic       arb_gnt_id_s;
    logic       arb_gnt_valid_s;
    logic       arb_last_nxt_s;

    assign arb_req_s = {p1_rd_req | p1_wr_req, p0_rd_req | p0_wr_req};

    rr_arb2 u_rr_arb2 (
        .req            (arb_req_s),
        .last_grant     (last_grant_q),
        .en             (state_q == ST_IDLE),
        .gnt_id         (arb_gnt_id_s),
        .gnt_valid      (arb_gnt_valid_s),
        .last_grant_nxt (arb_last_nxt_s)
    );

    // Next-state, latch and output logic for the single-transaction FSM.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = arb_last_nxt_s;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        ready_d      = 2'b00;
        err_d        = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (arb_gnt_valid_s) begin
                    state_d = ST_ISSUE;
                    id_d    = arb_gnt_id_s;
                    if (arb_gnt_id_s) begin
                        op_d    = sel_op(p1_wr_req);
                        addr_d  = p1_addr;
                        wdata_d = p1_wdata;
                    end else begin
                        op_d    = sel_op(p0_wr_req);
                        addr_d  = p0_addr;
                        wdata_d = p0_wdata;
                    end
                    // Start pulse is registered so it is high during ISSUE.
                    if (op_d == OP_WR) begin
                        mem_wr_d = 1'b1;
                    end else begin
                        mem_rd_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                // mem_ready takes priority over the watchdog in the same cycle.
                if (mem_ready) begin
                    state_d = ST_RESP;
                    ready_d = id_q ? 2'b10 : 2'b01;
                    if (op_q == OP_RD) begin
                        if (id_q) begin
                            p1_rdata_d = mem_rdata;
                        end else begin
                            p0_rdata_d = mem_rdata;
                        end
                    end else begin
                        p0_rdata_d = p0_rdata_q;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    // Counter reaches the limit on this edge; it stops there.
                    state_d = ST_RESP;
                    cnt_d   = CNT_LIMIT;
                    ready_d = id_q ? 2'b10 : 2'b01;
                    err_d   = id_q ? 2'b10 : 2'b01;
                    if (id_q) begin
                        p1_rdata_d = '0;
                    end else begin
                        p0_rdata_d = '0;
                    end
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE) ? 1'b1 : 1'b0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_RD;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            ready_q      <= 2'b00;
            err_q        <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign p0_rdata      = p0_rdata_q;
    assign p1_rdata      = p1_rdata_q;
    assign p0_ready      = ready_q[0];
    assign p1_ready      = ready_q[1];
    assign p0_err        = err_q[0];
    assign p1_err        = err_q[1];
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_read_req  = mem_rd_q;
    assign mem_write_req = mem_wr_q;
    assign busy          = busy_q;
    assign grant_id      = id_q;

endmodule
